// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared constants for the arithmetic result collector
package arith_pkg;

  localparam int DATA_W        = 16;
  localparam int PAYLOAD_W     = DATA_W + 1;
  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_ACC_W = 24;
  localparam int COUNT_W       = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - result FIFO with wrapping pointers and occupancy counter
module result_fifo
  import arith_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = PAYLOAD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             not_empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Head is read straight from storage; not_empty comes from the registered count
  assign head      = mem[rd_ptr];
  assign not_empty = (count != '0);
  assign full      = (count == CNT_W'(DEPTH));

  // Storage: zeroed on reset so the head reads 0 while reset is held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !clear) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; clear empties the queue and wins over push/pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/arith_result_collector.sv
// rtl/arith_result_collector.sv - queues arithmetic results and keeps running totals
module arith_result_collector
  import arith_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int ACC_W = DEFAULT_ACC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_op,
  input  logic [DATA_W-1:0]  in_result,
  input  logic               clear,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_op,
  output logic [ACC_W-1:0]   acc_sum,
  output logic [COUNT_W-1:0] acc_count,
  output logic               overflow
);

  logic                 fifo_full;
  logic                 fifo_valid;
  logic                 pop;
  logic                 push;
  logic                 drop;
  logic [PAYLOAD_W-1:0] head;
  logic [ACC_W:0]       sum_ext;

  // A full FIFO still takes a result when the head leaves on the same edge
  assign pop  = fifo_valid && out_ready && !clear;
  assign push = in_valid && !clear && (!fifo_full || pop);
  assign drop = in_valid && !clear && fifo_full && !pop;

  assign out_valid = fifo_valid;
  assign out_op    = head[PAYLOAD_W-1];
  assign out_data  = head[DATA_W-1:0];

  assign sum_ext = {1'b0, acc_sum} + (ACC_W + 1)'(in_result);

  result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PAYLOAD_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push      (push),
    .pop       (pop),
    .wdata     ({in_op, in_result}),
    .head      (head),
    .not_empty (fifo_valid),
    .full      (fifo_full)
  );

  // Saturating sum and count of accepted results, plus sticky drop flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_sum   <= '0;
      acc_count <= '0;
      overflow  <= 1'b0;
    end else if (clear) begin
      acc_sum   <= '0;
      acc_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (push) begin
        acc_sum <= sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
        if (acc_count != {COUNT_W{1'b1}}) acc_count <= acc_count + COUNT_W'(1);
      end
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_arith_result_collector.sv
// tb/tb_arith_result_collector.sv - directed self-checking bench for arith_result_collector
module tb_arith_result_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_op;
  logic [15:0] in_result;
  logic        clear;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_op;
  logic [23:0] acc_sum;
  logic [7:0]  acc_count;
  logic        overflow;

  int total  = 0;
  int passed = 0;

  arith_result_collector #(.DEPTH(4), .ACC_W(24)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_op     (in_op),
    .in_result (in_result),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_op    (out_op),
    .acc_sum   (acc_sum),
    .acc_count (acc_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] v, input logic op);
    in_valid  = 1'b1;
    in_result = v;
    in_op     = op;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    in_result = 16'h0;
    in_op     = 1'b0;
  endtask

  task automatic do_clear();
    idle();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; out_ready = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_op", out_op, 0);
    chk("rst_sum", acc_sum, 0);
    chk("rst_count", acc_count, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;

    // in-order delivery with tags, consumer always ready
    out_ready = 1'b1;
    drive(16'd8, 1'b0);  step();
    chk("order_v0", out_valid, 1);
    chk("order_d0", out_data, 8);
    chk("order_o0", out_op, 0);
    drive(16'd30, 1'b0); step();
    chk("order_d1", out_data, 30);
    chk("order_o1", out_op, 0);
    drive(16'd24, 1'b1); step();
    chk("order_d2", out_data, 24);
    chk("order_o2", out_op, 1);
    drive(16'd21, 1'b1); step();
    chk("order_d3", out_data, 21);
    chk("order_o3", out_op, 1);
    idle(); step();
    chk("order_empty", out_valid, 0);
    chk("order_sum", acc_sum, 83);
    chk("order_count", acc_count, 4);
    chk("order_ovf", overflow, 0);
    do_clear();
    chk("clr_sum", acc_sum, 0);
    chk("clr_count", acc_count, 0);

    // overflow when consumer stalls
    out_ready = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      drive(16'(v), 1'b0);
      step();
    end
    idle();
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", acc_count, 4);
    chk("ovf_sum", acc_sum, 10);
    chk("ovf_head", out_data, 1);
    out_ready = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      step();
      chk("ovf_drain", out_data, 32'(i));
    end
    step();
    chk("ovf_drained", out_valid, 0);
    chk("ovf_sticky", overflow, 1);
    out_ready = 1'b0;
    do_clear();
    chk("clr_ovf", overflow, 0);

    // push and pop together on a full FIFO
    for (int v = 1; v <= 4; v++) begin
      drive(16'(v), 1'b0);
      step();
    end
    chk("full_noovf", overflow, 0);
    drive(16'd9, 1'b0);
    out_ready = 1'b1;
    step();
    idle();
    out_ready = 1'b0;
    chk("pp_ovf", overflow, 0);
    chk("pp_head", out_data, 2);
    chk("pp_count", acc_count, 5);
    chk("pp_sum", acc_sum, 19);
    out_ready = 1'b1;
    step(); chk("pp_d3", out_data, 3);
    step(); chk("pp_d4", out_data, 4);
    step(); chk("pp_d9", out_data, 9);
    step(); chk("pp_empty", out_valid, 0);
    do_clear();

    // saturation of sum and count
    out_ready = 1'b1;
    drive(16'hFFFF, 1'b0);
    repeat (256) step();
    chk("sat_sum256", acc_sum, 32'hFFFF00);
    chk("sat_cnt256", acc_count, 255);
    step();
    chk("sat_sum257", acc_sum, 32'hFFFFFF);
    chk("sat_cnt257", acc_count, 255);
    chk("sat_ovf", overflow, 0);
    idle(); step();
    do_clear();

    // asynchronous reset mid-operation
    out_ready = 1'b0;
    drive(16'd5, 1'b0); step();
    drive(16'd6, 1'b0); step();
    drive(16'd7, 1'b0); step();
    idle();
    chk("ar_pre_valid", out_valid, 1);
    chk("ar_pre_count", acc_count, 3);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_data", out_data, 0);
    chk("ar_sum", acc_sum, 0);
    chk("ar_count", acc_count, 0);
    chk("ar_ovf", overflow, 0);
    #1 rst = 1'b0;
    drive(16'd7, 1'b0);
    step();
    idle();
    chk("ar_post_valid", out_valid, 1);
    chk("ar_post_data", out_data, 7);
    chk("ar_post_count", acc_count, 1);
    chk("ar_post_sum", acc_sum, 7);

    // clear beats a simultaneous push
    for (int i = 0; i < 4; i++) begin
      drive(16'd1, 1'b0);
      step();
    end
    idle();
    chk("cp_pre_ovf", overflow, 1);
    clear = 1'b1;
    drive(16'd55, 1'b1);
    step();
    clear = 1'b0;
    idle();
    chk("cp_valid", out_valid, 0);
    chk("cp_sum", acc_sum, 0);
    chk("cp_count", acc_count, 0);
    chk("cp_ovf", overflow, 0);
    step();
    chk("cp_not_stored", out_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
